// File: rtl/req_gnt_pkg.sv
// Shared types and elaboration helpers for the req/gnt arbiter.
package req_gnt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width helper that never returns zero, so a 1-entry range still gets a bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set, unmasked req bit after last_id, wrapping.
module rr_pick
  import req_gnt_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_id,
  input  logic [NUM_REQ-1:0] mask,
  output logic               found,
  output logic [IW-1:0]      idx
);

  always_comb begin
    int          sum;
    logic [IW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    cand  = '0;
    // Offset 1 first so the previous owner is considered last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = int'(last_id) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = IW'(sum);
      if (!found && req[cand] && !mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/req_gnt_arbiter.sv
// Round-robin req/gnt arbiter with bounded hold time and registered one-hot grant.
// Define REQ_GNT_ASSERT_EN to compile in the concurrent protocol assertions.
module req_gnt_arbiter
  import req_gnt_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic                             gnt_en,
  output logic [NUM_REQ-1:0]               gnt,
  output logic                             gnt_valid,
  output logic [clog2_min1(NUM_REQ)-1:0]   gnt_id
);

  localparam int            IW        = clog2_min1(NUM_REQ);
  localparam int            HW        = clog2_min1(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_e          state_reg, state_next;
  logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
  logic                valid_reg;
  logic [IW-1:0]       gnt_id_reg, gnt_id_next;
  logic [IW-1:0]       last_id_reg, last_id_next;
  logic [HW-1:0]       hold_cnt_reg, hold_cnt_next;

  logic [NUM_REQ-1:0]  pick_mask;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;

  // The current owner is never a rotation candidate; in IDLE nobody is excluded.
  assign pick_mask = (state_reg == GRANT) ? (NUM_REQ'(1) << gnt_id_reg) : '0;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req     (req),
    .last_id (last_id_reg),
    .mask    (pick_mask),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    gnt_id_next   = gnt_id_reg;
    last_id_next  = last_id_reg;
    hold_cnt_next = hold_cnt_reg;

    case (state_reg)
      IDLE: begin
        gnt_next = '0;
        if (gnt_en && pick_found) begin
          state_next    = GRANT;
          gnt_next      = NUM_REQ'(1) << pick_idx;
          gnt_id_next   = pick_idx;
          last_id_next  = pick_idx;
          hold_cnt_next = '0;
        end
      end
      GRANT: begin
        if (!gnt_en) begin
          state_next    = IDLE;
          gnt_next      = '0;
          hold_cnt_next = '0;
        end else if (!req[gnt_id_reg]) begin
          hold_cnt_next = '0;
          if (pick_found) begin
            gnt_next     = NUM_REQ'(1) << pick_idx;
            gnt_id_next  = pick_idx;
            last_id_next = pick_idx;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
          end
        end else if (hold_cnt_reg == HOLD_LAST) begin
          hold_cnt_next = '0;
          if (pick_found) begin
            gnt_next     = NUM_REQ'(1) << pick_idx;
            gnt_id_next  = pick_idx;
            last_id_next = pick_idx;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg + HW'(1);
        end
      end
      default: begin
        state_next    = IDLE;
        gnt_next      = '0;
        hold_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      valid_reg    <= 1'b0;
      gnt_id_reg   <= '0;
      last_id_reg  <= IW'(NUM_REQ - 1);
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      valid_reg    <= |gnt_next;
      gnt_id_reg   <= gnt_id_next;
      last_id_reg  <= last_id_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_valid = valid_reg;
  assign gnt_id    = gnt_id_reg;

`ifdef REQ_GNT_ASSERT_EN
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

  a_lone_req: assert property (@(posedge clk) disable iff (!rst_n)
    (state_reg == IDLE && gnt_en && $onehot(req)) |=> (gnt == $past(req)));

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt_had_req
      a_gnt_req: assert property (@(posedge clk) disable iff (!rst_n)
        gnt[gi] |-> $past(req[gi]));
    end
  endgenerate

  a_max_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_valid && gnt_en && req[gnt_id] && ((req & ~gnt) != '0) && hold_cnt_reg == HOLD_LAST)
      |=> (gnt != $past(gnt)));

  a_valid: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));
`endif

endmodule

// File: tb/tb_req_gnt_arbiter.sv
// Scoreboard bench for req_gnt_arbiter: a reference model queues expected outputs per cycle.
module tb_req_gnt_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic         gnt_en = 1'b0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;

  always #5 clk = ~clk;

  req_gnt_arbiter #(
    .NUM_REQ  (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt_en    (gnt_en),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  bit       m_busy;
  logic [1:0] m_id;
  logic [1:0] m_last;
  int       m_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_id   = 2'd0;
    m_last = 2'd3;
    m_hold = 0;
  endtask

  // Returns {found, index} of the first requester after 'last', skipping masked bits.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] last,
                                      input logic [3:0] mask);
    logic [1:0] j;
    for (int k = 1; k <= 4; k++) begin
      j = last + 2'(k);
      if (r[j] && !mask[j]) return {1'b1, j};
    end
    return 3'b000;
  endfunction

  task automatic model_edge(input logic [3:0] r, input logic e);
    logic [2:0] p;
    if (m_busy) begin
      if (!e) begin
        m_busy = 1'b0;
        m_hold = 0;
      end else if (!r[m_id]) begin
        p = pick(r, m_last, 4'b0000);
        m_hold = 0;
        if (p[2]) begin
          m_id   = p[1:0];
          m_last = p[1:0];
        end else begin
          m_busy = 1'b0;
        end
      end else if (m_hold == MH - 1) begin
        m_hold = 0;
        p = pick(r, m_last, 4'b0001 << m_id);
        if (p[2]) begin
          m_id   = p[1:0];
          m_last = p[1:0];
        end
      end else begin
        m_hold++;
      end
    end else if (e && (|r)) begin
      p = pick(r, m_last, 4'b0000);
      m_busy = 1'b1;
      m_id   = p[1:0];
      m_last = p[1:0];
      m_hold = 0;
    end
  endtask

  // One transaction: drive on negedge, queue the model's prediction, compare after the edge.
  task automatic step(input logic [3:0] r, input logic e);
    exp_t ex;
    exp_t want;
    @(negedge clk);
    req    = r;
    gnt_en = e;
    model_edge(r, e);
    ex.gnt   = m_busy ? (4'b0001 << m_id) : 4'b0000;
    ex.valid = m_busy;
    ex.id    = m_id;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    cyc++;
    want = exp_q.pop_front();
    check("gnt", 32'(gnt), 32'(want.gnt));
    check("gnt_valid", 32'(gnt_valid), 32'(want.valid));
    check("gnt_id", 32'(gnt_id), 32'(want.id));
    $display("cyc %0d req=%b en=%b -> gnt=%b valid=%b id=%0d", cyc, r, e, gnt, gnt_valid, gnt_id);
  endtask

  initial begin
    logic [3:0] prev_g;
    int         run;

    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(gnt_valid), 32'd0);
    check("rst_id", 32'(gnt_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lone requester: grant one cycle after request, release one cycle after drop.
    step(4'b0000, 1'b1);
    step(4'b0001, 1'b1);
    check("first_grant", 32'(gnt), 32'b0001);
    for (int i = 0; i < 3; i++) step(4'b0001, 1'b1);
    step(4'b0000, 1'b1);
    check("release", 32'(gnt), 32'd0);

    // Full contention: each owner keeps the grant exactly MH cycles, no gaps.
    prev_g = 4'b0000;
    run    = 0;
    for (int i = 0; i < 40; i++) begin
      step(4'b1111, 1'b1);
      check("no_gap", 32'(gnt_valid), 32'd1);
      if (gnt == prev_g) begin
        run++;
      end else begin
        if (prev_g != 4'b0000) check("hold_len", 32'(run), 32'(MH));
        run    = 1;
        prev_g = gnt;
      end
    end
    step(4'b0000, 1'b1);

    // Owner drop with others pending: direct handover in pointer order.
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    step(4'b1101, 1'b1);
    check("handover", 32'(gnt), 32'b0100);
    step(4'b0000, 1'b1);

    // Uncontended owner keeps the grant across hold counter reloads.
    for (int i = 0; i < 30; i++) begin
      step(4'b0100, 1'b1);
      check("single_hold", 32'(gnt), 32'b0100);
    end

    // gnt_en low forces release; re-enable regrants the same requester.
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 1'b0);
      check("en_low", 32'(gnt), 32'd0);
    end
    step(4'b0100, 1'b1);
    check("en_resume", 32'(gnt), 32'b0100);

    // Asynchronous reset between edges clears the grant without a clock.
    #3;
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'd0);
    check("async_rst_valid", 32'(gnt_valid), 32'd0);
    check("async_rst_id", 32'(gnt_id), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1000, 1'b1);
    check("post_rst_grant", 32'(gnt), 32'b1000);
    step(4'b0000, 1'b1);
    step(4'b1001, 1'b1);
    check("tie_req0", 32'(gnt), 32'b0001);
    step(4'b0000, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 150; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
